// File: rtl/leg_pkg.sv
// Shared definitions for the LEG program loader and fetch unit.
// Both sides use these offsets so that they agree on the instruction-word layout.
package leg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    PAYLOAD = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  // Instruction word {dir, data_a, data_b, address}: top bit of each byte field
  localparam int DIR_HI  = 31;
  localparam int A_HI    = 23;
  localparam int B_HI    = 15;
  localparam int ADDR_HI = 7;

endpackage

// File: rtl/leg_byte_timeout.sv
// Idle-cycle watchdog for the loader: counts cycles without an accepted byte.
// o_expired is high in the cycle that completes the TIMEOUT-th idle cycle.
module leg_byte_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  logic [19:0] r_cnt;

  assign o_expired = i_en && !i_clr && (r_cnt == 20'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

endmodule

// File: rtl/leg_prog_loader.sv
// Framed byte-stream loader for LEG program memory; holds the core in reset
// until a frame with a good checksum has been written.
//
//  state   | meaning
//  IDLE    | hunting for HEADER, other bytes dropped
//  COUNT   | next byte is the word count (0 = 256)
//  PAYLOAD | collecting the 4 bytes of one instruction word
//  WRITE   | one-cycle memory write, input stalled
//  CHECK   | next byte is the checksum
module leg_prog_loader
  import leg_pkg::*;
#(
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] HEADER  = HEADER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      r_state;
  logic [8:0]  r_count;
  logic [1:0]  r_idx;
  logic [7:0]  r_sum;
  logic [31:0] r_word;
  logic [7:0]  r_addr;
  logic        r_we;
  logic        r_done;
  logic        r_err;
  logic        r_cpu_rst_n;

  logic        w_accept;
  logic        w_to_en;
  logic        w_expired;
  logic [7:0]  w_sum_chk;

  assign in_ready  = (r_state != WRITE);
  assign w_accept  = in_valid && in_ready;
  assign w_to_en   = (r_state == COUNT) || (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_sum_chk = r_sum + in_data;

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_data  = r_word;
  assign cpu_rst_n = r_cpu_rst_n;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;

  leg_byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_to_en),
    .i_clr     (w_accept),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_word      <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Release the core one cycle after the done pulse; a new HEADER below overrides
      if (r_done) r_cpu_rst_n <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept && (in_data == HEADER)) begin
            r_state     <= COUNT;
            r_cpu_rst_n <= 1'b0;
          end
        end
        COUNT: begin
          if (w_accept) begin
            r_count <= {(in_data == 8'd0), in_data};
            r_addr  <= '0;
            r_idx   <= '0;
            r_sum   <= in_data;
            r_state <= PAYLOAD;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        PAYLOAD: begin
          if (w_accept) begin
            r_word[DIR_HI -: 8]  <= r_word[A_HI -: 8];
            r_word[A_HI -: 8]    <= r_word[B_HI -: 8];
            r_word[B_HI -: 8]    <= r_word[ADDR_HI -: 8];
            r_word[ADDR_HI -: 8] <= in_data;
            r_sum <= w_sum_chk;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_state <= WRITE;
            end
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        WRITE: begin
          r_addr  <= r_addr + 8'd1;
          r_count <= r_count - 9'd1;
          r_state <= (r_count == 9'd1) ? CHECK : PAYLOAD;
        end
        CHECK: begin
          if (w_accept) begin
            if (w_sum_chk == 8'd0) r_done <= 1'b1;
            else                   r_err  <= 1'b1;
            r_state <= IDLE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leg_prog_loader.sv
// Directed bench for leg_prog_loader: frames, checksum outcomes, junk bytes,
// idle timeout and asynchronous reset in the middle of a frame.
module tb_leg_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          wr_n, done_n, err_n, nrdy_n;
  logic [7:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  always #5 clk = ~clk;

  leg_prog_loader #(
    .TIMEOUT (16),
    .HEADER  (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = mem_addr;
          wr_data[wr_n] = mem_data;
        end
        wr_n = wr_n + 1;
      end
      if (done)      done_n = done_n + 1;
      if (err)       err_n  = err_n + 1;
      if (!in_ready) nrdy_n = nrdy_n + 1;
    end
  end

  task automatic clear_mon();
    wr_n = 0; done_n = 0; err_n = 0; nrdy_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready byte=%h got=%b exp=1", b, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (in_ready  !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (mem_we    !== 1'b0)  begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr  !== 8'h00) begin bad++; $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); end
    total++; if (mem_data  !== 32'h0) begin bad++; $display("FAIL rst_mem_data got=%h exp=0", mem_data); end
    total++; if (cpu_rst_n !== 1'b0)  begin bad++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    total++; if (busy      !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done      !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (err       !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] v [0:5];
    v = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    clear_mon();
    send_byte(8'hA5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int i = 0; i < 6; i++) send_byte(v[i]);
    total++; if (done      !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", done); end
    total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL single_cpu_early got=%b exp=0", cpu_rst_n); end
    @(posedge clk); #1;
    total++; if (done      !== 1'b0) begin bad++; $display("FAIL single_done_width got=%b exp=0", done); end
    total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL single_cpu_run got=%b exp=1", cpu_rst_n); end
    repeat (2) @(negedge clk);
    total++; if (wr_n != 1) begin bad++; $display("FAIL single_wr_count got=%0d exp=1", wr_n); end
    total++; if (wr_addr[0] !== 8'h00) begin bad++; $display("FAIL single_addr got=%h exp=00", wr_addr[0]); end
    total++; if (wr_data[0] !== 32'h01020304) begin bad++; $display("FAIL single_data got=%h exp=01020304", wr_data[0]); end
    total++; if (done_n != 1 || err_n != 0) begin bad++; $display("FAIL single_pulses got=done%0d/err%0d exp=done1/err0", done_n, err_n); end
    total++; if (nrdy_n != 1) begin bad++; $display("FAIL single_stall got=%0d exp=1", nrdy_n); end
  endtask

  task automatic test_two_words();
    logic [7:0] v [0:10];
    // 02 + (10..17) = 0x9E, so the balancing checksum is 0x62
    v = '{8'hA5, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h62};
    clear_mon();
    for (int i = 0; i < 11; i++) send_byte(v[i]);
    repeat (3) @(negedge clk);
    total++; if (wr_n != 2) begin bad++; $display("FAIL two_wr_count got=%0d exp=2", wr_n); end
    total++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h10111213) begin bad++; $display("FAIL two_word0 got=%h:%h exp=00:10111213", wr_addr[0], wr_data[0]); end
    total++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h14151617) begin bad++; $display("FAIL two_word1 got=%h:%h exp=01:14151617", wr_addr[1], wr_data[1]); end
    total++; if (nrdy_n != 2) begin bad++; $display("FAIL two_stall got=%0d exp=2", nrdy_n); end
    total++; if (done_n != 1 || err_n != 0) begin bad++; $display("FAIL two_pulses got=done%0d/err%0d exp=done1/err0", done_n, err_n); end
    total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL two_cpu_run got=%b exp=1", cpu_rst_n); end
  endtask

  task automatic test_junk();
    logic [7:0] j [0:2];
    logic [7:0] v [0:5];
    j = '{8'h00, 8'hFF, 8'h5A};
    v = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_byte(j[i]);
      total++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL junk_idle byte=%h got=cpu%b/busy%b exp=cpu1/busy0", j[i], cpu_rst_n, busy); end
    end
    send_byte(8'hA5);
    total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL junk_hdr_drop got=%b exp=0", cpu_rst_n); end
    for (int i = 0; i < 6; i++) send_byte(v[i]);
    @(posedge clk); #1;
    total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL junk_cpu_run got=%b exp=1", cpu_rst_n); end
    repeat (2) @(negedge clk);
    total++; if (wr_n != 1 || wr_data[0] !== 32'hDEADBEEF || wr_addr[0] !== 8'h00) begin bad++; $display("FAIL junk_write got=%0d:%h:%h exp=1:00:deadbeef", wr_n, wr_addr[0], wr_data[0]); end
    total++; if (done_n != 1) begin bad++; $display("FAIL junk_done got=%0d exp=1", done_n); end
  endtask

  task automatic test_bad_chk();
    logic [7:0] v [0:6];
    v = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF4};
    clear_mon();
    for (int i = 0; i < 7; i++) send_byte(v[i]);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL badchk_err got=%b exp=1", err); end
    repeat (4) @(negedge clk);
    total++; if (err_n != 1 || done_n != 0) begin bad++; $display("FAIL badchk_pulses got=err%0d/done%0d exp=err1/done0", err_n, done_n); end
    total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL badchk_cpu got=%b exp=0", cpu_rst_n); end
    total++; if (wr_n != 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h01020304) begin bad++; $display("FAIL badchk_mem got=%0d:%h:%h exp=1:00:01020304", wr_n, wr_addr[0], wr_data[0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badchk_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] v [0:6];
    v = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    clear_mon();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'hAA);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (err) break;
    end
    total++; if (n != 16) begin bad++; $display("FAIL timeout_latency got=%0d exp=16", n); end
    total++; if (busy !== 1'b0 || cpu_rst_n !== 1'b0) begin bad++; $display("FAIL timeout_state got=busy%b/cpu%b exp=busy0/cpu0", busy, cpu_rst_n); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_err_width got=%b exp=0", err); end
    clear_mon();
    for (int i = 0; i < 7; i++) send_byte(v[i]);
    repeat (3) @(negedge clk);
    total++; if (done_n != 1 || wr_n != 1 || wr_data[0] !== 32'h01020304) begin bad++; $display("FAIL timeout_reload got=done%0d/wr%0d/%h exp=done1/wr1/01020304", done_n, wr_n, wr_data[0]); end
    total++; if (cpu_rst_n !== 1'b1) begin bad++; $display("FAIL timeout_cpu_run got=%b exp=1", cpu_rst_n); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v [0:6];
    v = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 7; i++) send_byte(v[i]);
    total++; if (busy !== 1'b1 || mem_addr !== 8'h01) begin bad++; $display("FAIL mid_pre got=busy%b/addr%h exp=busy1/addr01", busy, mem_addr); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_data !== 32'h0) begin bad++; $display("FAIL mid_rst_mem got=%b%b:%h:%h exp=10:00:00000000", in_ready, mem_we, mem_addr, mem_data); end
    total++; if (cpu_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=cpu%b/busy%b/done%b/err%b exp=0000", cpu_rst_n, busy, done, err); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    v = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    for (int i = 0; i < 7; i++) send_byte(v[i]);
    repeat (3) @(negedge clk);
    total++; if (done_n != 1 || wr_n != 1 || wr_addr[0] !== 8'h00) begin bad++; $display("FAIL mid_recover got=done%0d/wr%0d/addr%h exp=done1/wr1/addr00", done_n, wr_n, wr_addr[0]); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_two_words();
    test_junk();
    test_bad_chk();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finished");
    $fatal(1);
  end

endmodule
